// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin denominations, hopper encodings,
// dispenser state encoding and product prices.
package vending_pkg;

  localparam int NUM_HOPPERS = 5;

  localparam int DENOM_20 = 20;
  localparam int DENOM_10 = 10;
  localparam int DENOM_5  = 5;
  localparam int DENOM_2  = 2;
  localparam int DENOM_1  = 1;

  // Hopper bit order is {20,10,5,2,1}, MSB = largest coin.
  localparam logic [4:0] HOP_20 = 5'b10000;
  localparam logic [4:0] HOP_10 = 5'b01000;
  localparam logic [4:0] HOP_5  = 5'b00100;
  localparam logic [4:0] HOP_2  = 5'b00010;
  localparam logic [4:0] HOP_1  = 5'b00001;

  localparam int PRICE_25 = 25;
  localparam int PRICE_50 = 50;
  localparam int PRICE_75 = 75;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_FINISH
  } disp_state_t;

  // Coin value of hopper bit position idx.
  function automatic int unsigned denom_of(input int idx);
    case (idx)
      4:       return DENOM_20;
      3:       return DENOM_10;
      2:       return DENOM_5;
      1:       return DENOM_2;
      default: return DENOM_1;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_coin_inventory.sv
// Five saturating stock counters, one per coin hopper, with registered
// empty flags in the same {20,10,5,2,1} bit order as the hopper requests.
module coin_inventory
  import vending_pkg::*;
#(
  parameter int CNT_W      = 6,
  parameter int INIT_COUNT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refill,
  input  logic [4:0] dec,
  input  logic [4:0] clr,
  output logic [4:0] empty
);

  localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(INIT_COUNT);

  logic [CNT_W-1:0] cnt      [NUM_HOPPERS];
  logic [CNT_W-1:0] cnt_next [NUM_HOPPERS];

  // Refill loads the base value first, so a coincident ejection still counts.
  always_comb begin
    for (int i = 0; i < NUM_HOPPERS; i++) begin
      // NOTE: each element gets a value on every path; a missing default here would infer a latch.
      cnt_next[i] = refill ? INIT_VAL : cnt[i];
      if (clr[i])
        cnt_next[i] = '0;
      else if (dec[i] && (cnt_next[i] != '0))
        cnt_next[i] = cnt_next[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: stock is architectural state, so the counter array is reset rather than left at power-up values.
      for (int i = 0; i < NUM_HOPPERS; i++) begin
        cnt[i]   <= INIT_VAL;
        empty[i] <= (INIT_VAL == '0);
      end
    end else begin
      // NOTE: non-blocking updates keep every counter sampling pre-edge values, independent of statement order.
      for (int i = 0; i < NUM_HOPPERS; i++) begin
        cnt[i]   <= cnt_next[i];
        empty[i] <= (cnt_next[i] == '0);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount out of five coin hoppers, largest coin first, one coin
// per request/ack handshake; reports any unpaid shortfall and jammed hoppers.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int AMT_W       = 8,
  parameter int CNT_W       = 6,
  parameter int INIT_COUNT  = 20,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AMT_W-1:0] change_in,
  input  logic             change_valid,
  input  logic             refill,
  input  logic             hopper_ack,
  output logic [4:0]       hopper_req,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic [4:0]       empty,
  output logic             fault
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  disp_state_t      state, state_next;
  logic [AMT_W-1:0] remaining, remaining_next;
  logic [AMT_W-1:0] shortfall_next;
  logic [4:0]       hopper_req_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic             fault_next;
  logic [4:0]       pick;
  logic [4:0]       dec, clr;
  logic [AMT_W-1:0] cur_denom;

  coin_inventory #(
    .CNT_W      (CNT_W),
    .INIT_COUNT (INIT_COUNT)
  ) u_inventory (
    .clk    (clk),
    .reset  (reset),
    .refill (refill),
    .dec    (dec),
    .clr    (clr),
    .empty  (empty)
  );

  // Ascending scan: larger eligible coins overwrite smaller ones.
  always_comb begin
    pick = '0;
    for (int i = 0; i < NUM_HOPPERS; i++) begin
      if (!empty[i] && (AMT_W'(denom_of(i)) <= remaining)) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

  always_comb begin
    cur_denom = '0;
    for (int i = 0; i < NUM_HOPPERS; i++)
      if (hopper_req[i]) cur_denom = AMT_W'(denom_of(i));
  end

  always_comb begin
    state_next      = state;
    remaining_next  = remaining;
    shortfall_next  = shortfall;
    hopper_req_next = hopper_req;
    wait_next       = wait_cnt;
    fault_next      = fault;
    dec             = '0;
    clr             = '0;

    // A timeout in the same cycle as refill still leaves the flag set.
    if (refill) fault_next = 1'b0;

    case (state)
      ST_IDLE: begin
        if (change_valid) begin
          remaining_next = change_in;
          shortfall_next = '0;
          state_next     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (remaining == '0) begin
          state_next = ST_FINISH;
        end else if (pick == '0) begin
          shortfall_next = remaining;
          state_next     = ST_FINISH;
        end else begin
          hopper_req_next = pick;
          wait_next       = '0;
          state_next      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (hopper_ack) begin
          remaining_next  = remaining - cur_denom;
          dec             = hopper_req;
          hopper_req_next = '0;
          state_next      = ST_SELECT;
        end else if (wait_cnt == WAIT_LAST) begin
          // Jammed hopper: write its stock off and carry on with smaller coins.
          fault_next      = 1'b1;
          clr             = hopper_req;
          hopper_req_next = '0;
          state_next      = ST_SELECT;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      shortfall  <= '0;
      hopper_req <= '0;
      wait_cnt   <= '0;
      fault      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      remaining  <= remaining_next;
      shortfall  <= shortfall_next;
      hopper_req <= hopper_req_next;
      wait_cnt   <= wait_next;
      fault      <= fault_next;
      busy       <= (state_next != ST_IDLE);
      done       <= (state_next == ST_FINISH);
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench: two dispensers (full stock and INIT_COUNT=2), an automatic
// hopper responder, and a monitor that matches coin requests and done pulses.
module tb_change_dispenser;
  import vending_pkg::*;

  localparam int AMT_W = 8;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [AMT_W-1:0] change_in    [2];
  logic             change_valid [2];
  logic             refill       [2];
  logic             hopper_ack   [2];
  logic [4:0]       hopper_req   [2];
  logic             busy         [2];
  logic             done         [2];
  logic [AMT_W-1:0] shortfall    [2];
  logic [4:0]       empty        [2];
  logic             fault        [2];

  logic [4:0] jam_mask   [2];
  logic       refill_on5 [2];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       is_done;
    logic [7:0] value;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(6), .INIT_COUNT(20), .ACK_TIMEOUT(16)) u_dut (
    .clk (clk), .reset (reset),
    .change_in (change_in[0]), .change_valid (change_valid[0]),
    .refill (refill[0]), .hopper_ack (hopper_ack[0]),
    .hopper_req (hopper_req[0]), .busy (busy[0]), .done (done[0]),
    .shortfall (shortfall[0]), .empty (empty[0]), .fault (fault[0])
  );

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(6), .INIT_COUNT(2), .ACK_TIMEOUT(16)) u_dut_small (
    .clk (clk), .reset (reset),
    .change_in (change_in[1]), .change_valid (change_valid[1]),
    .refill (refill[1]), .hopper_ack (hopper_ack[1]),
    .hopper_req (hopper_req[1]), .busy (busy[1]), .done (done[1]),
    .shortfall (shortfall[1]), .empty (empty[1]), .fault (fault[1])
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic flag_fail(input string name, input logic [31:0] actual);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d (0x%0h), expected no event", name, actual, actual);
  endtask

  function automatic void q_push(input int inst, input logic is_done, input logic [7:0] v);
    exp_t e;
    e.is_done = is_done;
    e.value   = v;
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endfunction

  function automatic int q_size(input int inst);
    return (inst == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t q_pop(input int inst);
    if (inst == 0) return q0.pop_front();
    else           return q1.pop_front();
  endfunction

  task automatic push_seq(input int inst, input logic [4:0] coins[$], input logic [7:0] short_amt);
    foreach (coins[k]) q_push(inst, 1'b0, {3'b000, coins[k]});
    q_push(inst, 1'b1, short_amt);
  endtask

  task automatic start_pay(input int inst, input logic [7:0] amt);
    @(negedge clk);
    change_in[inst]    = amt;
    change_valid[inst] = 1'b1;
    @(negedge clk);
    change_valid[inst] = 1'b0;
  endtask

  task automatic wait_idle(input int inst, input string name);
    int n = 0;
    while ((q_size(inst) != 0 || busy[inst]) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(n >= BUDGET), 32'd0);
  endtask

  // Hopper model: eject on the half-cycle after a request unless the hopper is jammed.
  initial begin
    for (int i = 0; i < 2; i++) begin
      hopper_ack[i] = 1'b0;
      refill[i]     = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        hopper_ack[i] = 1'b0;
        refill[i]     = 1'b0;
        if (!reset && hopper_req[i] != '0 && (hopper_req[i] & jam_mask[i]) == '0) begin
          hopper_ack[i] = 1'b1;
          if (refill_on5[i] && hopper_req[i] == HOP_5) refill[i] = 1'b1;
        end
      end
    end
  end

  // Monitor: every new request and every done pulse must match the scoreboard head.
  initial begin
    logic [4:0] prev_req [2];
    exp_t e;
    for (int i = 0; i < 2; i++) prev_req[i] = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          prev_req[i] = '0;
        end else begin
          if (hopper_req[i] != '0 && prev_req[i] == '0) begin
            if (q_size(i) == 0) begin
              flag_fail($sformatf("unexpected_req_%0d", i), 32'(hopper_req[i]));
            end else begin
              e = q_pop(i);
              check($sformatf("event_is_req_%0d", i), 32'(e.is_done), 32'd0);
              check($sformatf("req_coin_%0d", i), 32'(hopper_req[i]), 32'(e.value));
            end
          end
          if (done[i]) begin
            if (q_size(i) == 0) begin
              flag_fail($sformatf("unexpected_done_%0d", i), 32'(shortfall[i]));
            end else begin
              e = q_pop(i);
              check($sformatf("event_is_done_%0d", i), 32'(e.is_done), 32'd1);
              check($sformatf("done_shortfall_%0d", i), 32'(shortfall[i]), 32'(e.value));
            end
          end
          prev_req[i] = hopper_req[i];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] coins[$];
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      change_in[i]    = '0;
      change_valid[i] = 1'b0;
      jam_mask[i]     = '0;
      refill_on5[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_req",       32'(hopper_req[0]), 32'd0);
    check("rst_busy",      32'(busy[0]),       32'd0);
    check("rst_done",      32'(done[0]),       32'd0);
    check("rst_shortfall", 32'(shortfall[0]),  32'd0);
    check("rst_empty",     32'(empty[0]),      32'd0);
    check("rst_fault",     32'(fault[0]),      32'd0);

    // 88 with full stock: 20x4, 5, 2, 1
    coins = '{HOP_20, HOP_20, HOP_20, HOP_20, HOP_5, HOP_2, HOP_1};
    push_seq(0, coins, 8'd0);
    start_pay(0, 8'd88);
    wait_idle(0, "pay88");
    check("pay88_empty", 32'(empty[0]), 32'd0);
    check("pay88_fault", 32'(fault[0]), 32'd0);

    // Zero change: done two cycles after the strobe, no coins
    q_push(0, 1'b1, 8'd0);
    @(negedge clk);
    change_in[0]    = 8'd0;
    change_valid[0] = 1'b1;
    @(negedge clk);
    change_valid[0] = 1'b0;
    check("zero_busy_c1", 32'(busy[0]), 32'd1);
    check("zero_done_c1", 32'(done[0]), 32'd0);
    @(negedge clk);
    check("zero_done_c2", 32'(done[0]), 32'd1);
    wait_idle(0, "zero");

    // Strobe while busy is dropped: only 30 is paid
    coins = '{HOP_20, HOP_10};
    push_seq(0, coins, 8'd0);
    start_pay(0, 8'd30);
    change_in[0]    = 8'd50;
    change_valid[0] = 1'b1;
    @(negedge clk);
    change_valid[0] = 1'b0;
    wait_idle(0, "busy_drop");
    repeat (4) @(negedge clk);
    check("busy_drop_idle", 32'(busy[0]), 32'd0);

    // Jammed 20-hopper: timeout, fault, then 10x4
    jam_mask[0] = HOP_20;
    coins = '{HOP_20, HOP_10, HOP_10, HOP_10, HOP_10};
    push_seq(0, coins, 8'd0);
    start_pay(0, 8'd40);
    wait_idle(0, "jam20");
    check("jam20_fault", 32'(fault[0]), 32'd1);
    check("jam20_empty", 32'(empty[0]), 32'(HOP_20));

    // Reset during REQ restores stock and clears everything
    jam_mask[0] = HOP_10;
    q_push(0, 1'b0, {3'b000, HOP_10});
    start_pay(0, 8'd10);
    begin
      int n = 0;
      while (q_size(0) != 0 && n < BUDGET) begin
        @(negedge clk);
        n++;
      end
      check("rst_mid_req_timeout", 32'(n >= BUDGET), 32'd0);
    end
    repeat (2) @(negedge clk);
    check("rst_mid_req_held", 32'(hopper_req[0]), 32'(HOP_10));
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_req",       32'(hopper_req[0]), 32'd0);
    check("rst_mid_busy",      32'(busy[0]),       32'd0);
    check("rst_mid_done",      32'(done[0]),       32'd0);
    check("rst_mid_shortfall", 32'(shortfall[0]),  32'd0);
    check("rst_mid_fault",     32'(fault[0]),      32'd0);
    check("rst_mid_empty",     32'(empty[0]),      32'd0);
    jam_mask[0] = '0;
    reset = 1'b0;
    @(negedge clk);

    // INIT_COUNT=2, 255: two of each coin (76), shortfall 179
    coins = '{HOP_20, HOP_20, HOP_10, HOP_10, HOP_5, HOP_5, HOP_2, HOP_2, HOP_1, HOP_1};
    push_seq(1, coins, 8'd179);
    start_pay(1, 8'd255);
    wait_idle(1, "drain");
    check("drain_empty", 32'(empty[1]), 32'h1f);
    repeat (4) @(negedge clk);
    check("drain_shortfall_held", 32'(shortfall[1]), 32'd179);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Refill coincident with the 5-hopper ack: fault cleared, stock[5] = 1
    jam_mask[1]   = HOP_20;
    refill_on5[1] = 1'b1;
    coins = '{HOP_20, HOP_10, HOP_10, HOP_5};
    push_seq(1, coins, 8'd0);
    start_pay(1, 8'd25);
    wait_idle(1, "refill_ack");
    check("refill_ack_fault", 32'(fault[1]), 32'd0);
    check("refill_ack_empty", 32'(empty[1]), 32'd0);
    jam_mask[1]   = '0;
    refill_on5[1] = 1'b0;
    coins = '{HOP_10, HOP_5};
    push_seq(1, coins, 8'd0);
    start_pay(1, 8'd15);
    wait_idle(1, "after_refill");
    check("after_refill_empty", 32'(empty[1]), 32'(HOP_5));

    repeat (3) @(negedge clk);
    check("q0_drained", 32'(q_size(0)), 32'd0);
    check("q1_drained", 32'(q_size(1)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
